// File: rtl/pal_timing_pkg.sv
// rtl/pal_timing_pkg.sv - shared constants for the PAL-style timing generator
//
// Purpose: default raster timing, counter widths and DAC level codes used by
//          pal_timing_gen and pal_level_mux.
// Ports:   none (package).
// Macro:   none here; PAL_TEST_PATTERN_EN is consumed by pal_level_mux.

package pal_timing_pkg;

   // Counter widths: h covers 0..1023, v covers 0..311.
   localparam int unsigned H_W = 10;
   localparam int unsigned V_W = 9;

   // Default raster: 64 us lines at 16 MHz, 312 non-interlaced lines.
   localparam int unsigned DEF_LINE_CLKS         = 1024;
   localparam int unsigned DEF_HSYNC_CLKS        = 75;
   localparam int unsigned DEF_BACK_PORCH_CLKS   = 93;
   localparam int unsigned DEF_ACTIVE_CLKS       = 832;
   localparam int unsigned DEF_LINES             = 312;
   localparam int unsigned DEF_VSYNC_LINES       = 3;
   localparam int unsigned DEF_FIRST_ACTIVE_LINE = 23;
   localparam int unsigned DEF_ACTIVE_LINES      = 270;

   localparam int unsigned DEF_H_ACT_START = DEF_HSYNC_CLKS + DEF_BACK_PORCH_CLKS;

   // 5-bit resistor-ladder codes.
   localparam logic [4:0] SYNC_LEVEL  = 5'd0;
   localparam logic [4:0] BLANK_LEVEL = 5'd9;

endpackage

// File: rtl/pal_level_mux.sv
// rtl/pal_level_mux.sv - priority select of the DAC level for one clock
//
// Purpose: sync beats active beats blank. Inside the active window the level
//          is either flat blank (overlay supplies content downstream) or a
//          set of grey bars when PAL_TEST_PATTERN_EN is defined.
// Ports:
//   sync    in  1   sync tip for this clock
//   active  in  1   inside the active picture window
//   pixel_x in  10  active pixel index (0 outside the window)
//   level   out 5   DAC code (combinational)
// Macro:   PAL_TEST_PATTERN_EN - enables the grey-bar test pattern.

module pal_level_mux
   import pal_timing_pkg::*;
(
   input  logic           sync,
   input  logic           active,
   input  logic [H_W-1:0] pixel_x,
   output logic [4:0]     level
);

`ifdef PAL_TEST_PATTERN_EN
   // One bar per 128 pixels; bar index 0..6 scales to +0..+18 on top of
   // blank, so the result stays within 5 bits.
   logic [4:0] bar_level;
   assign bar_level = BLANK_LEVEL + (5'd3 * {2'b00, pixel_x[H_W-1:H_W-3]});
`else
   logic unused_pixel_x;
   assign unused_pixel_x = ^pixel_x;
`endif

   always_comb begin
      level = BLANK_LEVEL;
      if (sync) begin
         level = SYNC_LEVEL;
      end else if (active) begin
`ifdef PAL_TEST_PATTERN_EN
         level = bar_level;
`else
         level = BLANK_LEVEL;
`endif
      end
   end

endmodule

// File: rtl/pal_timing_gen.sv
// rtl/pal_timing_gen.sv - free-running PAL-style composite timing generator
//
// Purpose: line/frame counters plus registered sync, active window,
//          coordinates, strobes and DAC level. All outputs are decoded from
//          the current (h_cnt, v_cnt) and registered, so they lag the
//          counters by one clock and stay coherent with each other.
// Ports:
//   clk         in  1   16 MHz board clock
//   rst         in  1   synchronous, active-high reset
//   sync        out 1   1 = sync tip (level 0)
//   active      out 1   1 = inside active picture window
//   pixel_x     out 10  active pixel index, 0 outside window
//   line_y      out 9   active line index, 0 outside active lines
//   line_start  out 1   strobe at h=0 of every line
//   frame_start out 1   strobe at h=0, v=0
//   level       out 5   DAC code
// Macro:   PAL_TEST_PATTERN_EN (via pal_level_mux) - grey-bar test pattern.

module pal_timing_gen
   import pal_timing_pkg::*;
#(
   parameter int unsigned LINE_CLKS         = DEF_LINE_CLKS,
   parameter int unsigned HSYNC_CLKS        = DEF_HSYNC_CLKS,
   parameter int unsigned BACK_PORCH_CLKS   = DEF_BACK_PORCH_CLKS,
   parameter int unsigned ACTIVE_CLKS       = DEF_ACTIVE_CLKS,
   parameter int unsigned LINES             = DEF_LINES,
   parameter int unsigned VSYNC_LINES       = DEF_VSYNC_LINES,
   parameter int unsigned FIRST_ACTIVE_LINE = DEF_FIRST_ACTIVE_LINE,
   parameter int unsigned ACTIVE_LINES      = DEF_ACTIVE_LINES
)
(
   input  logic           clk,
   input  logic           rst,
   output logic           sync,
   output logic           active,
   output logic [H_W-1:0] pixel_x,
   output logic [V_W-1:0] line_y,
   output logic           line_start,
   output logic           frame_start,
   output logic [4:0]     level
);

   // Build-time legality of the raster.
   if (!(HSYNC_CLKS + BACK_PORCH_CLKS + ACTIVE_CLKS < LINE_CLKS) ||
       !(FIRST_ACTIVE_LINE + ACTIVE_LINES <= LINES) ||
       !(VSYNC_LINES < FIRST_ACTIVE_LINE) ||
       !(LINE_CLKS <= (1 << H_W)) ||
       !(LINES < (1 << V_W))) begin : g_illegal_timing
      $error("pal_timing_gen: illegal timing parameters");
   end

   // Decode thresholds at counter width so every compare is unsigned h/v.
   localparam logic [H_W-1:0] H_LAST      = H_W'(LINE_CLKS - 1);
   localparam logic [H_W-1:0] H_SYNC_END  = H_W'(HSYNC_CLKS);
   localparam logic [H_W-1:0] H_BROAD_END = H_W'(LINE_CLKS - HSYNC_CLKS);
   localparam logic [H_W-1:0] H_ACT_START = H_W'(HSYNC_CLKS + BACK_PORCH_CLKS);
   localparam logic [H_W-1:0] H_ACT_END   = H_W'(HSYNC_CLKS + BACK_PORCH_CLKS + ACTIVE_CLKS);
   localparam logic [V_W-1:0] V_LAST      = V_W'(LINES - 1);
   localparam logic [V_W-1:0] V_VSYNC_END = V_W'(VSYNC_LINES);
   localparam logic [V_W-1:0] V_ACT_START = V_W'(FIRST_ACTIVE_LINE);
   localparam logic [V_W-1:0] V_ACT_END   = V_W'(FIRST_ACTIVE_LINE + ACTIVE_LINES);

   logic [H_W-1:0] h_cnt_q, h_cnt_d;
   logic [V_W-1:0] v_cnt_q, v_cnt_d;

   logic           sync_q, sync_d;
   logic           active_q, active_d;
   logic [H_W-1:0] pixel_x_q, pixel_x_d;
   logic [V_W-1:0] line_y_q, line_y_d;
   logic           line_start_q, line_start_d;
   logic           frame_start_q, frame_start_d;
   logic [4:0]     level_q, level_d;

   logic           broad_line;
   logic           h_in_act;
   logic           v_in_act;

   // Counters: v advances and wraps on the same edge that h wraps.
   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end
   end

   // Output decode from the current counter position.
   always_comb begin
      broad_line    = (v_cnt_q < V_VSYNC_END);
      h_in_act      = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
      v_in_act      = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);

      // Broad lines invert the normal pulse: long tip, short gap at line end.
      sync_d        = broad_line ? (h_cnt_q < H_BROAD_END) : (h_cnt_q < H_SYNC_END);
      active_d      = h_in_act && v_in_act;
      pixel_x_d     = active_d ? (h_cnt_q - H_ACT_START) : '0;
      line_y_d      = active_d ? (v_cnt_q - V_ACT_START) : '0;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   pal_level_mux u_level_mux (
      .sync    (sync_d),
      .active  (active_d),
      .pixel_x (pixel_x_d),
      .level   (level_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         sync_q        <= 1'b0;
         active_q      <= 1'b0;
         pixel_x_q     <= '0;
         line_y_q      <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         level_q       <= BLANK_LEVEL;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         sync_q        <= sync_d;
         active_q      <= active_d;
         pixel_x_q     <= pixel_x_d;
         line_y_q      <= line_y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         level_q       <= level_d;
      end
   end

   assign sync        = sync_q;
   assign active      = active_q;
   assign pixel_x     = pixel_x_q;
   assign line_y      = line_y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign level       = level_q;

endmodule

// File: doc/pal_timing_gen.md
Name: pal_timing_gen

Overview:
- Free-running composite-video timing generator for the OSD path.
- Runs on the 16 MHz board clock.
- Produces line/frame counters, sync tips, an active-video window, pixel/line coordinates and a 5-bit DAC level.
- Feeds the frame-tracking/overlay stage, whose 5-bit output drives the resistor-ladder pins. Non-interlaced 312-line PAL-style raster, 64 us lines.

Parameters:
- LINE_CLKS, 1024, clocks per line (64 us at 16 MHz)
- HSYNC_CLKS, 75, normal horizontal sync tip width
- BACK_PORCH_CLKS, 93, clocks from sync end to active start
- ACTIVE_CLKS, 832, active pixels per line
- LINES, 312, lines per frame
- VSYNC_LINES, 3, broad-pulse lines at frame start
- FIRST_ACTIVE_LINE, 23, first line with active video
- ACTIVE_LINES, 270, number of active lines
- BLANK_LEVEL, 9, 5-bit DAC code for blank/black

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sync  out  1  1 = sync tip (DAC level 0)
- active  out  1  1 = inside active picture window
- pixel_x  out  10  active pixel index, 0 outside window
- line_y  out  9  active line index, 0 outside active lines
- line_start  out  1  one-cycle strobe at h=0 of every line
- frame_start  out  1  one-cycle strobe at h=0, v=0
- level  out  5  DAC code for the current clock

Behaviour:
- Interface:
  - One clock, `clk`.
  - Reset `rst` is synchronous and active-high; the polarity and synchronicity are fixed.
- Counters:
  - h_cnt is 0..LINE_CLKS-1; v_cnt is 0..LINES-1.
  - h_cnt increments every cycle. At LINE_CLKS-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps LINES-1 -> 0 on the same edge that h_cnt wraps.
- Reset:
  - rst=1 forces h_cnt=0, v_cnt=0.
  - All outputs register to: sync=0, active=0, pixel_x=0, line_y=0, line_start=0, frame_start=0, level=BLANK_LEVEL.
  - Reset mid-frame takes effect at the next edge with no partial-line completion.
- Latency: every output is registered from the current (h_cnt, v_cnt), so outputs lag the counters by exactly 1 cycle. All outputs are mutually coherent.
- First cycle after reset release: outputs show (0,0): frame_start=1, line_start=1, sync=1, level=0.
- Sync decode:
  - Normal line (v >= VSYNC_LINES): sync=1 when h < HSYNC_CLKS.
  - Broad line (v < VSYNC_LINES): sync=1 when h < LINE_CLKS-HSYNC_CLKS (949 clocks low, 75 high).
- Active decode:
  - H_ACT_START = HSYNC_CLKS+BACK_PORCH_CLKS (168).
  - active=1 iff FIRST_ACTIVE_LINE <= v < FIRST_ACTIVE_LINE+ACTIVE_LINES and H_ACT_START <= h < H_ACT_START+ACTIVE_CLKS.
- Coordinates:
  - When active: pixel_x = h-H_ACT_START and line_y = v-FIRST_ACTIVE_LINE; otherwise both are 0.
  - line_y is 0 (not held) on non-active lines.
- Level, priority order:
  - sync -> 0.
  - active -> per Optional Feature.
  - otherwise BLANK_LEVEL.
- Legality:
  - H_ACT_START+ACTIVE_CLKS < LINE_CLKS.
  - FIRST_ACTIVE_LINE+ACTIVE_LINES <= LINES.
  - VSYNC_LINES < FIRST_ACTIVE_LINE.
  - Violations are a build-time error (generate-time check).
- Arithmetic: all comparisons unsigned, at counter width (h 10 bits, v 9 bits). No overflow beyond the wrap points.

Optional Feature:
- Macro: PAL_TEST_PATTERN_EN.
- Defined: active level = BLANK_LEVEL + 3*pixel_x[9:7], giving vertical grey bars 9,12,...,27 (bar 6 is a 64-pixel stub). Arithmetic is 5-bit and cannot exceed 31 with default parameters.
- Undefined: active level = BLANK_LEVEL; the downstream overlay supplies picture content.

Decomposition:
- Package pal_timing_pkg holds:
  - default timing constants and derived H_ACT_START
  - counter width constants (H_W=10, V_W=9)
  - the level code constants SYNC_LEVEL=0 and BLANK_LEVEL=9
- One sub-module, pal_level_mux: combinational priority select of sync/active/blank plus the optional bar pattern. It keeps the macro-dependent logic isolated from the counters.

Test Plan:
- Reset release, run 1 cycle -> frame_start=1, line_start=1, sync=1, level=0. Next cycle frame_start=0.
- Run a full normal line (v=10) -> sync high for exactly 75 cycles, active=0 for whole line, level=9 after sync, line_start period 1024.
- Active line v=23 -> active rises at h=168 with pixel_x=0, line_y=0. Falls after h=999 (pixel_x=831). pixel_x/line_y=0 outside.
- Broad line v=0..2 -> sync high 949 cycles, low 75. v=3 reverts to 75-cycle sync. frame_start period = 319488 cycles.
- With PAL_TEST_PATTERN_EN on line 100: pixel_x 0->9, 128->12, 768->27; without the macro, level=9 throughout active.
- Assert rst at v=150, h=500 for 1 cycle -> next cycle outputs at reset values. Following cycle frame_start=1; the partial frame is discarded.
